// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences the read and write ports of an 8x16 register file for
// one latched 16-bit instruction (MOV imm, MOV reg, ADD, CMP, AND, MVN). It keeps
// Z/N/V status flags and uses a start/wait handshake.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   s, instr           start strobe and instruction, accepted only while w=1
//   w                  high in the wait state (ready for a new instruction)
//   illegal            one-cycle pulse when the latched instruction is unsupported
//   Z, N, V            status flags
//   rf_readnum         register file read index; rf_data_out is its read data
//   rf_writenum, rf_write, rf_data_in   register file write port
//
// Build option: define REGFILE_CTRL_SHIFT_EN to apply the sh field to operand B.
// Without it, sh is ignored and B passes through unshifted.
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic        Z,
  output logic        N,
  output logic        V,
  output logic [2:0]  rf_readnum,
  input  logic [15:0] rf_data_out,
  output logic [2:0]  rf_writenum,
  output logic        rf_write,
  output logic [15:0] rf_data_in
);

`ifdef REGFILE_CTRL_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StWait, StDecode, StWrImm, StReadA, StReadB, StExec, StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, a_q, b_q, c_q, c_d;
  logic        z_q, n_q, v_q, z_d, n_d, v_d;

  // Instruction fields
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic [15:0] imm_sx;
  assign opcode = instr_q[15:13];
  assign op     = instr_q[12:11];
  assign rn     = instr_q[10:8];
  assign rd     = instr_q[7:5];
  assign sh     = ShiftEn ? instr_q[4:3] : 2'b00;
  assign rm     = instr_q[2:0];
  assign imm_sx = {{8{instr_q[7]}}, instr_q[7:0]};

  logic is_alu, is_mov_imm, is_mov_reg;
  assign is_alu     = (opcode == 3'b101);
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);

  // Shifted operand B and ALU result
  logic [15:0] b_sh, sum, diff, result;
  logic        v_res;

  always_comb begin
    unique case (sh)
      2'b01:   b_sh = {b_q[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[15:1]};
      2'b11:   b_sh = {b_q[15], b_q[15:1]};
      default: b_sh = b_q;
    endcase
  end

  assign sum  = a_q + b_sh;
  assign diff = a_q - b_sh;

  always_comb begin
    result = b_sh;  // MOV reg
    v_res  = 1'b0;
    if (is_alu) begin
      unique case (op)
        2'b00: begin
          result = sum;
          v_res  = (a_q[15] == b_sh[15]) && (sum[15] != a_q[15]);
        end
        2'b01: begin
          result = diff;
          v_res  = (a_q[15] != b_sh[15]) && (diff[15] != a_q[15]);
        end
        2'b10:   result = a_q & b_sh;
        default: result = ~b_sh;
      endcase
    end
  end

  // Next state, datapath next values and outputs
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    w           = 1'b0;
    illegal     = 1'b0;
    rf_readnum  = 3'd0;
    rf_writenum = 3'd0;
    rf_write    = 1'b0;
    rf_data_in  = 16'd0;
    unique case (state_q)
      StWait: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm)                            state_d = StWrImm;
        else if (is_mov_reg || (is_alu && op == 2'b11)) state_d = StReadB;
        else if (is_alu)                           state_d = StReadA;
        else begin
          illegal = 1'b1;
          state_d = StWait;
        end
      end
      StWrImm: begin
        rf_write    = 1'b1;
        rf_writenum = rn;
        rf_data_in  = imm_sx;
        state_d     = StWait;
      end
      StReadA: begin
        rf_readnum = rn;
        state_d    = StReadB;
      end
      StReadB: begin
        rf_readnum = rm;
        state_d    = StExec;
      end
      StExec: begin
        c_d = result;
        if (is_alu) begin
          z_d = (result == 16'd0);
          n_d = result[15];
          v_d = v_res;
        end
        state_d = (is_alu && op == 2'b01) ? StWait : StWrite;
      end
      StWrite: begin
        rf_write    = 1'b1;
        rf_writenum = rd;
        rf_data_in  = c_q;
        state_d     = StWait;
      end
      default: state_d = StWait;
    endcase
    // A write coinciding with reset must not reach the register file.
    if (reset) rf_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      instr_q <= 16'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      c_q     <= 16'd0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      if (state_q == StWait && s) instr_q <= instr;
      if (state_q == StReadA)     a_q <= rf_data_out;
      if (state_q == StReadB)     b_q <= rf_data_out;
    end
  end

  assign Z = z_q;
  assign N = n_q;
  assign V = v_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;
  logic        clk = 1'b0;
  logic        reset, s, w, illegal, Z, N, V, rf_write;
  logic [15:0] instr, rf_data_out, rf_data_in;
  logic [2:0]  rf_readnum, rf_writenum;

  regfile_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .illegal(illegal),
    .Z(Z), .N(N), .V(V), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in)
  );

  always #5 clk = ~clk;

  // Register file model
  logic [15:0] regs [8];
  assign rf_data_out = regs[rf_readnum];
  always @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;

`ifdef REGFILE_CTRL_SHIFT_EN
  localparam logic [15:0] AddExp = 16'h0003;
`else
  localparam logic [15:0] AddExp = 16'h0005;
`endif

  typedef struct packed {
    logic [2:0]  num;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  illegal_cnt = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every register write must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (illegal) illegal_cnt++;
    if (rf_write) begin
      check("write_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_num", 16'(rf_writenum), 16'(e.num));
        check("wr_data", rf_data_in, e.data);
      end
    end
  end

  task automatic push(input logic [2:0] num, input logic [15:0] data);
    wr_t e;
    e.num  = num;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for w after an accept edge, returning cycles counted from it.
  task automatic wait_w(output int cyc);
    cyc = 1;
    while (!w && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic issue(input string name, input logic [15:0] ins, input int lat,
                       input int ill_exp);
    int cyc;
    int ill0;
    @(negedge clk);
    check({name, "_ready"}, 16'(w), 16'd1);
    ill0  = illegal_cnt;
    s     = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    s = 1'b0;
    wait_w(cyc);
    check({name, "_cycles"}, 16'(cyc), 16'(lat));
    check({name, "_illegal"}, 16'(illegal_cnt - ill0), 16'(ill_exp));
  endtask

  task automatic flags(input string name, input logic z, input logic n, input logic v);
    check({name, "_flags"}, {13'd0, Z, N, V}, {13'd0, z, n, v});
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 8; i++) regs[i] = 16'h5555;
    s = 1'b0; instr = 16'd0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_w", 16'(w), 16'd1);
    check("rst_outs", {11'd0, illegal, rf_write, Z, N, V}, 16'd0);
    check("rst_idx", {10'd0, rf_readnum, rf_writenum}, 16'd0);
    check("rst_data", rf_data_in, 16'd0);
    @(negedge clk) reset = 1'b0;

    push(3'd0, 16'h0007);  issue("mov_r0", 16'hD007, 3, 0); flags("mov_r0", 0, 0, 0);
    push(3'd1, 16'hFFFE);  issue("mov_r1", 16'hD1FE, 3, 0);
    push(3'd2, AddExp);    issue("add", 16'hA049, 6, 0);    flags("add", 0, 0, 0);
    issue("cmp", 16'hA800, 5, 0);                           flags("cmp", 1, 0, 0);
    push(3'd3, 16'hFFF8);  issue("mvn", 16'hB860, 5, 0);    flags("mvn", 0, 1, 0);
    push(3'd4, 16'hFFFE);  issue("movreg", 16'hC081, 5, 0); flags("movreg", 0, 1, 0);
    issue("illegal", 16'h0000, 2, 1);                       flags("illegal", 0, 1, 0);

    // s held high across an ADD: one execution per WAIT visit.
    push(3'd2, AddExp);
    push(3'd2, AddExp);
    @(negedge clk);
    s = 1'b1; instr = 16'hA049;
    @(posedge clk); #1;
    wait_w(cyc);
    check("hold_cycles1", 16'(cyc), 16'd6);
    @(posedge clk); #1;
    s = 1'b0;
    check("hold_reaccept", 16'(w), 16'd0);
    wait_w(cyc);
    check("hold_cycles2", 16'(cyc), 16'd6);
    flags("hold", 0, 0, 0);

    // Reset during WRITE of ADD R5,R0,R1: the write must be suppressed.
    @(negedge clk);
    s = 1'b1; instr = 16'hA0A9;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_write", {12'd0, rf_write, rf_writenum}, 16'h000D);
    reset = 1'b1;
    #1;
    check("rst_suppress", 16'(rf_write), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_w", 16'(w), 16'd1);
    check("abort_outs", {11'd0, illegal, rf_write, Z, N, V}, 16'd0);
    check("abort_idx", {10'd0, rf_readnum, rf_writenum}, 16'd0);
    check("abort_data", rf_data_in, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("r5_kept", regs[5], 16'h5555);
    check("r0", regs[0], 16'h0007);
    check("r3", regs[3], 16'hFFF8);
    check("r4", regs[4], 16'hFFFE);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
